// File: rtl/shifter_pkg.sv
// Shared constants for the iterative shifter: data width, op encodings, FSM states.
// Optional feature macro: ITER_SHIFTER_FAST4_EN (4-bit steps while cnt >= 4).
package shifter_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   // Shift op encodings, taken straight from alu_op[1:0]
   localparam logic [1:0] SH_ROL = 2'b00;
   localparam logic [1:0] SH_SLL = 2'b01;
   localparam logic [1:0] SH_ROR = 2'b10;
   localparam logic [1:0] SH_SRL = 2'b11;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of the working register.
// With ITER_SHIFTER_FAST4_EN defined a 4-bit step is selectable via by4;
// otherwise only the 1-bit step exists.
module shift_step
   import shifter_pkg::*;
(
`ifdef ITER_SHIFTER_FAST4_EN
   input  logic              by4,
`endif
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] data_c
);

   logic [DATA_W-1:0] w_one;

   // Single-bit step: rotates wrap, logical shifts fill with zero
   always_comb begin
      w_one = data;
      case (op)
         SH_ROL:  w_one = {data[DATA_W-2:0], data[DATA_W-1]};
         SH_SLL:  w_one = {data[DATA_W-2:0], 1'b0};
         SH_ROR:  w_one = {data[0], data[DATA_W-1:1]};
         default: w_one = {1'b0, data[DATA_W-1:1]};
      endcase
   end

`ifdef ITER_SHIFTER_FAST4_EN
   logic [DATA_W-1:0] w_four;

   // Four-bit step with the same wrap/fill rules
   always_comb begin
      w_four = data;
      case (op)
         SH_ROL:  w_four = {data[DATA_W-5:0], data[DATA_W-1:DATA_W-4]};
         SH_SLL:  w_four = {data[DATA_W-5:0], 4'b0000};
         SH_ROR:  w_four = {data[3:0], data[DATA_W-1:4]};
         default: w_four = {4'b0000, data[DATA_W-1:4]};
      endcase
   end

   assign data_c = by4 ? w_four : w_one;
`else
   assign data_c = w_one;
`endif

endmodule

// File: rtl/iter_shifter.sv
// Iterative 16-bit shifter: captures an operand, steps it once per cycle
// in SHIFT, then pulses done with the registered result.
// Optional feature macro: ITER_SHIFTER_FAST4_EN (4-bit steps while cnt >= 4).
module iter_shifter
   import shifter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [CNT_W-1:0]  shamt,
   input  logic [DATA_W-1:0] in_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   logic [1:0]        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_work, w_work_nxt;
   logic [1:0]        r_op, w_op_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic [DATA_W-1:0] r_result, w_result_nxt;
   logic [DATA_W-1:0] w_step;
   logic [CNT_W-1:0]  w_dec;

`ifdef ITER_SHIFTER_FAST4_EN
   logic w_by4;
   assign w_by4 = (r_cnt >= CNT_W'(4));
   assign w_dec = w_by4 ? CNT_W'(4) : CNT_W'(1);

   shift_step u_step (
      .by4    (w_by4),
      .op     (r_op),
      .data   (r_work),
      .data_c (w_step)
   );
`else
   assign w_dec = CNT_W'(1);

   shift_step u_step (
      .op     (r_op),
      .data   (r_work),
      .data_c (w_step)
   );
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_work_nxt   = r_work;
      w_op_nxt     = r_op;
      w_done_nxt   = 1'b0;
      w_result_nxt = r_result;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_work_nxt  = in_data;
               w_op_nxt    = op;
               w_cnt_nxt   = shamt;
               w_state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_work_nxt = w_step;
            w_cnt_nxt  = r_cnt - w_dec;
            if (r_cnt == w_dec) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done_nxt   = 1'b1;
            w_result_nxt = r_work;
            w_state_nxt  = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_work   <= '0;
         r_op     <= SH_ROL;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_work   <= w_work_nxt;
         r_op     <= w_op_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter.
// Honors ITER_SHIFTER_FAST4_EN for expected latencies.
module tb_iter_shifter;
   import shifter_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  shamt;
   logic [15:0] in_data;
   logic        busy;
   logic        done;
   logic [15:0] result;

   int n_total = 0;
   int n_bad   = 0;

   iter_shifter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .shamt   (shamt),
      .in_data (in_data),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_latency(input int s);
`ifdef ITER_SHIFTER_FAST4_EN
      return (s / 4) + (s % 4) + 1;
`else
      return s + 1;
`endif
   endfunction

   // Issue one operation, wait (bounded) for done, check latency and result
   task automatic run_op(input string tag, input logic [1:0] t_op, input logic [15:0] d,
                         input logic [3:0] s, input logic [15:0] exp);
      int lat;
      lat = 0;
      start = 1'b1; op = t_op; in_data = d; shamt = s;
      @(posedge clk); #1;
      start = 1'b0; op = ~t_op; in_data = ~d; shamt = ~s;
      check({tag, "_busy_acc"}, 32'(busy), 32'(s != 4'd0 || exp_latency(0) == 1));
      while (!done && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_latency(int'(s))));
      check({tag, "_res"}, 32'(result), 32'(exp));
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(result), 32'(exp));
   endtask

   initial begin
      int lat;
      int ndone;
      rst_n = 1'b0; start = 1'b0; op = SH_ROL; shamt = 4'd0; in_data = 16'h0000;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", 32'(result), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op("rol1",  SH_ROL, 16'h8001, 4'd1,  16'h0003);
      run_op("srl15", SH_SRL, 16'h8000, 4'd15, 16'h0001);
      run_op("ror4",  SH_ROR, 16'h0001, 4'd4,  16'h1000);
      run_op("sll0",  SH_SLL, 16'hFFFF, 4'd0,  16'hFFFF);
      run_op("sll4",  SH_SLL, 16'h1234, 4'd4,  16'h2340);
      run_op("rol8",  SH_ROL, 16'h1234, 4'd8,  16'h3412);
      run_op("ror5",  SH_ROR, 16'h8001, 4'd5,  16'h0C00);
      run_op("srl7",  SH_SRL, 16'hF0F0, 4'd7,  16'h01E1);
      run_op("rol13", SH_ROL, 16'hA5C3, 4'd13, 16'h74B8);

      // Back-to-back starts while busy must be ignored, inputs not resampled
      start = 1'b1; op = SH_SLL; in_data = 16'h0001; shamt = 4'd3;
      @(posedge clk); #1;
      lat = 0; ndone = 0;
      while (ndone == 0 && lat < 32) begin
         start = 1'b1; op = SH_ROL; in_data = 16'h0100 + 16'(lat); shamt = 4'd1;
         @(posedge clk); #1;
         lat++;
         if (done) ndone++;
      end
      start = 1'b0;
      check("seq_lat", 32'(lat), 32'd4);
      check("seq_res", 32'(result), 32'h0008);
      check("seq_busy", 32'(busy), 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("seq_ndone", 32'(ndone), 32'd1);
      check("seq_hold", 32'(result), 32'h0008);

      // Reset mid-shift aborts with no done pulse
      start = 1'b1; op = SH_ROL; in_data = 16'h1234; shamt = 4'd10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_res", 32'(result), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      ndone = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort_ndone", 32'(ndone), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      run_op("post_rst", SH_SLL, 16'h0003, 4'd2, 16'h000C);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
